// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state encoding and mode constants for count_seq_ctrl
package count_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/tff_up_counter.sv
// tff_up_counter: W-bit synchronous up-counter built from T flip-flops with sync clear
module tff_up_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] t;
  // each bit toggles when enabled and every lower bit is 1
  always_comb begin
    t[0] = en;
    for (int i = 1; i < W; i++) t[i] = t[i-1] & q[i-1];
  end
  // T flip-flop bank; clear wins over toggle
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= clr ? '0 : q ^ t;
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: command-driven sequencer for a T-FF up-counter; optional PAUSE_EN adds a PAUSED state
module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] term,
  input  logic         mode,
  input  logic         abort,
  input  logic         pause,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] count
);
  state_t state, state_n;
  logic [W-1:0] term_q;
  logic mode_q, en, clr, done_n, acc, pause_on;
`ifdef PAUSE_EN
  assign pause_on = pause;
`else
  assign pause_on = pause & 1'b0;
`endif
  assign ready = state == ST_IDLE;
  assign busy  = state != ST_IDLE;
  assign acc   = start & ready;
  tff_up_counter #(.W(W)) u_cnt (.clk(clk), .rst(rst), .en(en), .clr(clr), .q(count));
  // next state, counter controls and next done; abort > pause > terminal > count
  always_comb begin
    state_n = state;
    en = 1'b0;
    clr = 1'b0;
    done_n = 1'b0;
    case (state)
      ST_IDLE: begin
        clr = acc;
        state_n = acc ? ST_RUN : ST_IDLE;
      end
      ST_RUN:
        if (abort) begin
          clr = 1'b1;
          state_n = ST_IDLE;
        end else if (pause_on) state_n = ST_PAUSED;
        else if (count == term_q) begin
          done_n = 1'b1;
          clr = mode_q == MODE_PERIODIC;
          state_n = mode_q == MODE_PERIODIC ? ST_RUN : ST_IDLE;
        end else en = 1'b1;
      ST_PAUSED: begin
        clr = abort;
        state_n = abort ? ST_IDLE : pause_on ? ST_PAUSED : ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // state, done flag and command latches
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      term_q <= '0;
      mode_q <= MODE_ONESHOT;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= done_n;
      if (acc) begin
        term_q <= term;
        mode_q <= mode;
      end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed plus random stimulus against a behavioural model of count_seq_ctrl
module tb_count_seq_ctrl;
`ifdef PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 0, rst = 0, start = 0, mode = 0, abort = 0, pause = 0;
  logic [3:0] term = 0;
  logic ready, busy, done;
  logic [3:0] count;
  int n_vec = 0, n_err = 0;
  bit m_busy, m_paused, m_mode, m_done;
  int m_count, m_term;

  count_seq_ctrl #(.W(4)) dut (.clk(clk), .rst(rst), .start(start), .term(term), .mode(mode),
    .abort(abort), .pause(pause), .ready(ready), .busy(busy), .done(done), .count(count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_mode = 0; m_done = 0; m_count = 0; m_term = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_paused = 0; m_term = int'(term); m_mode = mode; m_count = 0;
      end
    end else if (abort) begin
      m_busy = 0; m_paused = 0; m_count = 0;
    end else if (PE && pause) m_paused = 1;
    else if (m_paused) m_paused = 0;
    else if (m_count == m_term) begin
      m_done = 1;
      if (m_mode) m_count = 0;
      else m_busy = 0;
    end else m_count = m_count + 1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, int'(count), m_count);
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".ready"}, int'(ready), int'(!m_busy));
    chk({tag, ".busy"}, int'(busy), int'(m_busy));
  endtask

  task automatic step(input string tag, input logic s, input logic [3:0] t, input logic m,
                      input logic a, input logic p);
    start = s; term = t; mode = m; abort = a; pause = p;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 chk_all("por");
    @(posedge clk); #1 rst = 1;
    step("os9_acc", 1, 9, 0, 0, 0);
    idle_steps("os9_run", 5);
    chk("mid_count5", int'(count), 5);
    #2 rst = 0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk); #1;
    chk_all("rst_hold");
    rst = 1;
    step("os3_acc", 1, 3, 0, 0, 0);
    idle_steps("os3_run", 3);
    chk("os3_pre_done", int'(done), 0);
    step("os3_term", 0, 0, 0, 0, 0);
    chk("os3_done", int'(done), 1);
    chk("os3_hold", int'(count), 3);
    idle_steps("os3_after", 2);
    step("per2_acc", 1, 2, 1, 0, 0);
    step("per2_busy_start", 1, 7, 0, 0, 0);
    idle_steps("per2_run", 8);
    step("per2_abort", 0, 0, 0, 1, 0);
    step("per0_acc", 1, 0, 1, 0, 0);
    idle_steps("per0_run", 4);
    chk("per0_done", int'(done), 1);
    step("per0_abort", 0, 0, 0, 1, 0);
    chk("per0_abort_done", int'(done), 0);
    step("t9_acc", 1, 9, 0, 0, 0);
    idle_steps("t9_run", 4);
    step("t9_abort", 0, 0, 0, 1, 0);
    chk("t9_abort_count", int'(count), 0);
    step("idle_abort", 0, 0, 0, 1, 0);
    step("start_abort", 1, 15, 0, 1, 0);
    chk("sa_busy", int'(busy), 1);
    idle_steps("t15_run", 16);
    chk("t15_done", int'(done), 1);
    chk("t15_count", int'(count), 15);
    idle_steps("t15_after", 2);
    step("p5_acc", 1, 5, 0, 0, 0);
    idle_steps("p5_run", 2);
    for (int i = 0; i < 3; i++) step("p5_pause", 0, 0, 0, 0, 1);
    idle_steps("p5_resume", 8);
    step("pt_acc", 1, 1, 0, 0, 0);
    step("pt_run", 0, 0, 0, 0, 0);
    step("pt_pause_term", 0, 0, 0, 0, 1);
    idle_steps("pt_resume", 4);
    for (int i = 0; i < 3000; i++)
      step("rand", $urandom_range(0, 3) == 0, 4'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
